awb_engine: RTL and testbench
=============================

Name: awb_engine

Overview:
- Parametrised auto-white-balance engine for the ISP stream path. Merges per-channel statistics, gain computation and gain application into one block.
- Gains are computed gray-world style over a frame (gain_c = sum_ref / sum_c) with a sequential divider.
- Sits after demosaic/denoise and before gamma.
- Mode-selectable: bypass, measure, apply, or measure-and-apply (apply stored gains while measuring new ones).

Parameters:
- COLOR_DEPTH, 8, pixel width
- NUM_CH, 3, colour channels
- CH_W, 2, color tag width (≥ clog2(NUM_CH))
- REF_CH, 1, reference channel (green)
- GAIN_BITS, 8, gain width
- GAIN_FRAC, 6, fractional gain bits (unity = 2^GAIN_FRAC)
- ACC_W, 28, per-channel accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (name kept per codebase)
- mode  in  2  0 bypass, 1 measure, 2 apply, 3 measure+apply; sampled on start
- start  in  1  begin frame; honoured only in IDLE
- pixel_in  in  COLOR_DEPTH  pixel value
- valid_in  in  1  pixel qualifier
- color_in  in  CH_W  channel tag
- last_pic_in  in  1  last pixel of frame (qualified by valid_in)
- pixel_out  out  COLOR_DEPTH  processed pixel
- valid_out  out  1  output qualifier
- color_out  out  CH_W  delayed color_in
- last_pic_out  out  1  delayed last_pic_in
- gain_out  out  NUM_CH*GAIN_BITS  stored gains, channel 0 in LSBs
- gain_valid  out  1  one-cycle pulse when gain_out updates
- busy  out  1  high when state != IDLE
- finish  out  1  one-cycle frame-done pulse

Behaviour:
- Reset: state IDLE; accumulators 0; every gain = 2^GAIN_FRAC (64); pipeline flushed; all outputs 0 except gain_out (unity). Reset mid-frame or mid-divide aborts: no finish, no gain update.
- FSM: IDLE -> STREAM on start (latch mode, clear accumulators). STREAM -> DIVIDE on valid_in&last_pic_in if mode[0]=1, else -> DRAIN. DRAIN: wait until last_pic_out has been emitted, pulse finish, -> IDLE. DIVIDE: runs channels 0..NUM_CH-1; on completion commit all gains at once, pulse gain_valid and finish in the same cycle (never before last_pic_out), -> IDLE.
- valid_in outside STREAM is dropped; a valid_in in the same cycle as start is dropped. start outside IDLE is ignored.
- Datapath: fixed 2-cycle latency in every mode (stage 1 multiply, stage 2 round/saturate). Sideband signals are delayed identically.
- Apply (modes 2, 3): out = min((pixel*gain[color] + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, 2^COLOR_DEPTH-1). Modes 0, 1 pass the pixel unchanged.
- color_in >= NUM_CH: pixel passes unchanged and is not accumulated.
- Measure (modes 1, 3): sum[color] += pixel on every accepted pixel; the sum saturates at 2^ACC_W-1.
- Mode 3 applies the old gains for the whole frame; new gains take effect only after the commit.
- Divider, per channel: 1 precheck cycle + GAIN_BITS restoring iterations.
  - Precheck: if sum_c==0 or sum_ref==0 -> gain 2^GAIN_FRAC.
  - Precheck: else if sum_ref >= sum_c << (GAIN_BITS-GAIN_FRAC) -> gain 2^GAIN_BITS-1.
  - Otherwise: gain = floor((sum_ref << GAIN_FRAC) / sum_c).
  - DIVIDE length = NUM_CH*(GAIN_BITS+1) cycles (27 with defaults).
- Internal division widths are ACC_W+GAIN_BITS; there is no truncation before the compare.

Test Plan:
- Bypass: mode0, pixels 10/20/30 (last on 30) -> same values 2 cycles later, last_pic_out on 30, finish 1 cycle after last_pic_out, gains stay 64.
- Measure: mode1, 4 each of R=50, G=100, B=200 -> pixels unchanged; after 27 DIVIDE cycles gain_out R=128, G=64, B=32; gain_valid and finish coincide.
- Apply after measure: mode2 with R=100 -> 200, R=200 -> 255 (saturated), B=100 -> 50, G=77 -> 77.
- Gain limits: R sum 10, G sum 1000, B sum 0 -> R=255, G=64, B=64.
- Mode3 over two frames: frame 1 applies unity gains and measures R gain 128; frame 2 R=100 -> 200; start during STREAM is ignored.
- Reset asserted mid-DIVIDE -> gain_out all 64, busy=0, no finish/gain_valid; a following mode0 frame behaves as the bypass case.

Source files
------------

// File: rtl/awb_engine_if.sv
// rtl/awb_engine_if.sv - pixel stream bundle (input and output sides) for awb_engine
interface awb_engine_if #(
  parameter int COLOR_DEPTH = 8,
  parameter int CH_W        = 2
);
  logic [COLOR_DEPTH-1:0] pixel_in;
  logic                   valid_in;
  logic [CH_W-1:0]        color_in;
  logic                   last_pic_in;
  logic [COLOR_DEPTH-1:0] pixel_out;
  logic                   valid_out;
  logic [CH_W-1:0]        color_out;
  logic                   last_pic_out;

  // upstream/downstream side: drives pixels in, observes pixels out
  modport master (
    output pixel_in, valid_in, color_in, last_pic_in,
    input  pixel_out, valid_out, color_out, last_pic_out
  );

  // engine side
  modport slave (
    input  pixel_in, valid_in, color_in, last_pic_in,
    output pixel_out, valid_out, color_out, last_pic_out
  );
endinterface

// File: rtl/awb_engine.sv
// rtl/awb_engine.sv - gray-world auto-white-balance: stats, sequential gain divide, gain apply
module awb_engine #(
  parameter int COLOR_DEPTH = 8,
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 2,
  parameter int REF_CH      = 1,
  parameter int GAIN_BITS   = 8,
  parameter int GAIN_FRAC   = 6,
  parameter int ACC_W       = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        start,
  awb_engine_if.slave                 s,
  output logic [NUM_CH*GAIN_BITS-1:0] gain_out,
  output logic                        gain_valid,
  output logic                        busy,
  output logic                        finish
);

  localparam int DIV_W  = ACC_W + GAIN_BITS;
  localparam int PROD_W = COLOR_DEPTH + GAIN_BITS;
  localparam int STEP_W = $clog2(GAIN_BITS + 1);
  localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GAIN_BITS-1:0] UNITY   = GAIN_BITS'(2 ** GAIN_FRAC);
  localparam logic [PROD_W:0]      PIX_MAX = (PROD_W + 1)'(2 ** COLOR_DEPTH - 1);
  localparam logic [PROD_W:0]      RND     = (PROD_W + 1)'(2 ** (GAIN_FRAC - 1));

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DIVIDE} state_t;

  state_t state_q, state_d;
  logic [1:0] mode_q;

  logic [ACC_W-1:0]     sum_q      [NUM_CH];
  logic [GAIN_BITS-1:0] gain_q     [NUM_CH];
  logic [GAIN_BITS-1:0] new_gain_q [NUM_CH];

  // stream pipeline
  logic                   accept;
  logic                   color_ok;
  logic [GAIN_BITS-1:0]   sel_gain;
  logic [ACC_W-1:0]       acc_sel;
  logic [ACC_W:0]         acc_add;
  logic [ACC_W-1:0]       acc_val;
  logic                   s1_valid, s1_last, s1_apply;
  logic [CH_W-1:0]        s1_color;
  logic [COLOR_DEPTH-1:0] s1_pix;
  logic [PROD_W-1:0]      s1_prod;
  logic [PROD_W:0]        rnd_sum, rnd_shift;
  logic [COLOR_DEPTH-1:0] applied;
  logic                   out_valid, out_last;
  logic [CH_W-1:0]        out_color;
  logic [COLOR_DEPTH-1:0] out_pixel;

  // divider
  logic [CNT_W-1:0]     div_ch;
  logic [STEP_W-1:0]    div_step;
  logic [DIV_W-1:0]     div_rem, rem_next, trial, dividend;
  logic [GAIN_BITS-1:0] div_q, q_next, div_force_val, div_result;
  logic                 div_forced;
  logic [ACC_W-1:0]     cur_sum, ref_sum;
  logic                 pre_zero, pre_sat, ge;
  int                   bit_idx;
  logic                 div_last_step, div_done, drain_done;

  assign accept = (state_q == STREAM) && s.valid_in;

  // per-colour gain and accumulator lookup; unknown colour tags match nothing
  always_comb begin
    color_ok = 1'b0;
    sel_gain = UNITY;
    acc_sel  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s.color_in == CH_W'(c)) begin
        color_ok = 1'b1;
        sel_gain = gain_q[c];
        acc_sel  = sum_q[c];
      end
    end
    acc_add = {1'b0, acc_sel} + (ACC_W + 1)'(s.pixel_in);
    acc_val = acc_add[ACC_W] ? '1 : acc_add[ACC_W-1:0];
  end

  // stage-2 rounding and saturation of the gained pixel
  always_comb begin
    rnd_sum   = {1'b0, s1_prod} + RND;
    rnd_shift = rnd_sum >> GAIN_FRAC;
    applied   = (rnd_shift > PIX_MAX) ? '1 : rnd_shift[COLOR_DEPTH-1:0];
  end

  // divider datapath: operand select, precheck and one restoring step
  always_comb begin
    cur_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (div_ch == CNT_W'(c)) cur_sum = sum_q[c];
    end
    ref_sum    = sum_q[REF_CH];
    pre_zero   = (cur_sum == '0) || (ref_sum == '0);
    pre_sat    = {{GAIN_BITS{1'b0}}, ref_sum} >=
                 ({{GAIN_BITS{1'b0}}, cur_sum} << (GAIN_BITS - GAIN_FRAC));
    dividend   = {{GAIN_BITS{1'b0}}, ref_sum} << GAIN_FRAC;
    bit_idx    = GAIN_BITS - int'(div_step);
    trial      = {{GAIN_BITS{1'b0}}, cur_sum} << bit_idx;
    ge         = div_rem >= trial;
    q_next     = ge ? (div_q | (GAIN_BITS'(1) << bit_idx)) : div_q;
    rem_next   = ge ? (div_rem - trial) : div_rem;
    div_result = div_forced ? div_force_val : q_next;
    div_last_step = (state_q == DIVIDE) && (div_step == STEP_W'(GAIN_BITS));
    div_done      = div_last_step && (div_ch == CNT_W'(NUM_CH - 1));
  end

  assign drain_done = (state_q == DRAIN) && out_valid && out_last;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && s.last_pic_in) state_d = mode_q[0] ? DIVIDE : DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      DIVIDE:  if (div_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register and mode latch
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) mode_q <= mode;
    end
  end

  // per-channel saturating statistics, cleared at frame start
  always_ff @(posedge clk) begin
    if (rst_n || (state_q == IDLE && start)) begin
      for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
    end else if (accept && mode_q[0] && color_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (s.color_in == CH_W'(c)) sum_q[c] <= acc_val;
      end
    end
  end

  // two-stage pixel pipeline; sideband travels with the data
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_apply  <= 1'b0;
      s1_color  <= '0;
      s1_pix    <= '0;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_color <= '0;
      out_pixel <= '0;
    end else begin
      s1_valid  <= accept;
      s1_last   <= accept && s.last_pic_in;
      s1_apply  <= mode_q[1] && color_ok;
      s1_color  <= s.color_in;
      s1_pix    <= s.pixel_in;
      s1_prod   <= PROD_W'(s.pixel_in) * PROD_W'(sel_gain);
      out_valid <= s1_valid;
      out_last  <= s1_last;
      out_color <= s1_color;
      out_pixel <= s1_apply ? applied : s1_pix;
    end
  end

  // sequential divider; all gains are committed together after the last channel
  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_ch        <= '0;
      div_step      <= '0;
      div_rem       <= '0;
      div_q         <= '0;
      div_forced    <= 1'b0;
      div_force_val <= UNITY;
      for (int c = 0; c < NUM_CH; c++) begin
        gain_q[c]     <= UNITY;
        new_gain_q[c] <= UNITY;
      end
    end else if (state_q == IDLE) begin
      div_ch   <= '0;
      div_step <= '0;
    end else if (state_q == DIVIDE) begin
      if (div_step == '0) begin
        div_forced    <= pre_zero || pre_sat;
        div_force_val <= pre_zero ? UNITY : '1;
        div_rem       <= dividend;
        div_q         <= '0;
        div_step      <= STEP_W'(1);
      end else begin
        div_rem <= rem_next;
        div_q   <= q_next;
        if (div_last_step) begin
          div_step <= '0;
          div_ch   <= div_ch + CNT_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (div_ch == CNT_W'(c)) new_gain_q[c] <= div_result;
          end
          if (div_done) begin
            for (int c = 0; c < NUM_CH; c++) begin
              gain_q[c] <= (div_ch == CNT_W'(c)) ? div_result : new_gain_q[c];
            end
          end
        end else begin
          div_step <= div_step + STEP_W'(1);
        end
      end
    end
  end

  // completion pulses
  always_ff @(posedge clk) begin
    if (rst_n) begin
      finish     <= 1'b0;
      gain_valid <= 1'b0;
    end else begin
      finish     <= drain_done || div_done;
      gain_valid <= div_done;
    end
  end

  // pack stored gains, channel 0 in the LSBs
  always_comb begin
    gain_out = '0;
    for (int c = 0; c < NUM_CH; c++) gain_out[c*GAIN_BITS +: GAIN_BITS] = gain_q[c];
  end

  assign busy           = (state_q != IDLE);
  assign s.pixel_out    = out_pixel;
  assign s.valid_out    = out_valid;
  assign s.color_out    = out_color;
  assign s.last_pic_out = out_last;

endmodule

// File: tb/tb_awb_engine.sv
// tb/tb_awb_engine.sv - self-checking bench for awb_engine with a frame-level model
module tb_awb_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        start;
  logic [23:0] gain_out;
  logic        gain_valid, busy, finish;

  always #5 clk = ~clk;

  awb_engine_if #(.COLOR_DEPTH(8), .CH_W(2)) bus ();

  awb_engine #(
    .COLOR_DEPTH(8), .NUM_CH(3), .CH_W(2), .REF_CH(1),
    .GAIN_BITS(8), .GAIN_FRAC(6), .ACC_W(28)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .s(bus.slave),
    .gain_out(gain_out), .gain_valid(gain_valid), .busy(busy), .finish(finish)
  );

  typedef struct {int pix; int col; bit last; int cyc;} exp_t;
  exp_t   expq[$];
  int     tests = 0, fails = 0;
  int     cyc = 0;
  int     mgain[3];
  longint msum[3];
  int     pend[3];
  bit     pend_v = 0, exp_gv = 0, exp_busy = 0;
  int     exp_fin = -1;
  int     mmode = 0;
  int     out_log[16];
  int     log_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // gray-world gain from frame sums, clamped as the engine defines
  function automatic int model_gain(input longint sc, input longint sr);
    if (sc == 0 || sr == 0) return 64;
    if (sr >= 4 * sc) return 255;
    return int'((sr * 64) / sc);
  endfunction

  function automatic int model_pix(input int p, input int g);
    int v;
    v = (p * g + 32) / 64;
    return (v > 255) ? 255 : v;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      if (bus.valid_out) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("pixel_out", bus.pixel_out, e.pix);
          chk("color_out", bus.color_out, e.col);
          chk("last_pic_out", bus.last_pic_out, e.last);
          chk("latency_cyc", cyc, e.cyc);
          if (log_n < 16) begin
            out_log[log_n] = int'(bus.pixel_out);
            log_n++;
          end
        end
      end
      if (gain_valid) begin
        chk("gain_valid_expected", pend_v, 1);
        chk("gain_out_commit", gain_out, {8'(pend[2]), 8'(pend[1]), 8'(pend[0])});
        for (int i = 0; i < 3; i++) mgain[i] = pend[i];
        pend_v = 0;
      end
      if (finish) begin
        chk("finish_cyc", cyc, exp_fin);
        chk("finish_with_gain_valid", gain_valid, exp_gv);
        exp_fin  = -1;
        exp_busy = 0;
      end
      chk("busy", busy, exp_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int m, input bit drop);
    mode = 2'(m);
    start = 1'b1;
    if (drop) begin
      bus.valid_in = 1'b1; bus.pixel_in = 8'd99; bus.color_in = 2'd0; bus.last_pic_in = 1'b1;
    end
    tick();
    start = 1'b0; bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
    mmode = m;
    for (int i = 0; i < 3; i++) msum[i] = 0;
    exp_busy = 1;
    log_n = 0;
  endtask

  task automatic send(input int p, input int c, input bit last);
    exp_t e;
    bus.pixel_in = 8'(p); bus.color_in = 2'(c); bus.last_pic_in = last; bus.valid_in = 1'b1;
    e.pix  = (c < 3 && mmode >= 2) ? model_pix(p, mgain[c]) : p;
    e.col  = c;
    e.last = last;
    e.cyc  = cyc + 2;
    expq.push_back(e);
    if ((mmode % 2) == 1 && c < 3) begin
      msum[c] = msum[c] + p;
      if (msum[c] > 268435455) msum[c] = 268435455;
    end
    if (last) begin
      if ((mmode % 2) == 1) begin
        for (int i = 0; i < 3; i++) pend[i] = model_gain(msum[i], msum[1]);
        pend_v  = 1;
        exp_gv  = 1;
        exp_fin = cyc + 28;
      end else begin
        exp_gv  = 0;
        exp_fin = cyc + 3;
      end
    end
    tick();
    bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_fin < 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no finish within 100 cycles, expected finish at cycle %0d", exp_fin);
      exp_fin  = -1;
      exp_busy = 0;
    end
    tick();
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; mode = 2'd0;
    bus.valid_in = 1'b0; bus.pixel_in = '0; bus.color_in = '0; bus.last_pic_in = 1'b0;
    for (int i = 0; i < 3; i++) mgain[i] = 64;
    repeat (3) tick();
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_gain_valid", gain_valid, 0);
    chk("rst_gain_out", gain_out, 24'h404040);
    rst_n = 1'b0;
    tick();

    // bypass, with a pixel coincident with start that must be dropped
    start_frame(0, 1);
    send(10, 0, 0); send(20, 1, 0); send(30, 2, 1);
    wait_done();
    chk("byp_px0", out_log[0], 10);
    chk("byp_px1", out_log[1], 20);
    chk("byp_px2", out_log[2], 30);
    chk("byp_gain", gain_out, 24'h404040);

    // measure
    start_frame(1, 0);
    for (int i = 0; i < 4; i++) begin
      send(50, 0, 0); send(100, 1, 0); send(200, 2, i == 3);
    end
    wait_done();
    chk("meas_gain", gain_out, 24'h204080);

    // apply stored gains, including an untagged colour
    start_frame(2, 0);
    send(100, 0, 0); send(200, 0, 0); send(123, 3, 0); send(100, 2, 0); send(77, 1, 1);
    wait_done();
    chk("app_r100", out_log[0], 200);
    chk("app_r200_sat", out_log[1], 255);
    chk("app_c3_pass", out_log[2], 123);
    chk("app_b100", out_log[3], 50);
    chk("app_g77", out_log[4], 77);

    // gain limits
    start_frame(1, 0);
    send(10, 0, 0);
    for (int i = 0; i < 4; i++) send(250, 1, i == 3);
    wait_done();
    chk("lim_gain", gain_out, 24'h4040FF);

    // reset in the middle of DIVIDE
    start_frame(1, 0);
    send(50, 0, 0); send(100, 1, 1);
    repeat (10) tick();
    rst_n = 1'b1;
    expq.delete();
    pend_v = 0; exp_fin = -1; exp_busy = 0;
    for (int i = 0; i < 3; i++) mgain[i] = 64;
    tick(); tick();
    rst_n = 1'b0;
    chk("abort_gain", gain_out, 24'h404040);
    chk("abort_busy", busy, 0);
    repeat (30) tick();

    start_frame(0, 0);
    send(10, 0, 0); send(20, 1, 0); send(30, 2, 1);
    wait_done();
    chk("byp2_px0", out_log[0], 10);
    chk("byp2_px2", out_log[2], 30);

    // measure+apply over two frames; a start mid-stream is ignored
    start_frame(3, 0);
    send(50, 0, 0);
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0; mode = 2'd3;
    send(100, 1, 1);
    wait_done();
    chk("m3f1_r", out_log[0], 50);
    chk("m3f1_g", out_log[1], 100);
    chk("m3f1_gain", gain_out, 24'h404080);

    start_frame(3, 0);
    send(100, 0, 0); send(100, 1, 1);
    wait_done();
    chk("m3f2_r", out_log[0], 200);
    chk("m3f2_gain", gain_out, 24'h404040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
